enc_8_3_seq: RTL and testbench
==============================

# enc_8_3_seq

Sequential 8-to-3 encoder that reverses the 3-to-8 decode path in our combinational circuits library. It accepts an 8-bit multi-hot request vector through a valid/ready handshake. It then emits the 3-bit index of every set bit, one index per output handshake, lowest index first. It converts a decoded event vector back into a stream of binary codes for downstream logic that handles one event at a time.

## Interface
- No parameters; widths fixed at 8 in / 3 out.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  d is valid.
- in_ready  output  1  block accepts d this cycle.
- d  input  8  request vector; bit i set means index i must be emitted.
- out_valid  output  1  a/last/count valid.
- out_ready  input  1  consumer takes the current beat.
- a  output  3  index of the lowest pending set bit.
- last  output  1  current beat is the final index of the captured vector.
- count  output  4  popcount of the captured vector (0..8).

## Operation
- States: IDLE and SCAN. Internal registers: state, pend[7:0], count[3:0].
- Input handshake occurs when in_valid & in_ready.
- Output handshake occurs when out_valid & out_ready.
- IDLE:
  - in_ready=1, out_valid=0.
  - On input handshake: pend<=d and count<=popcount(d).
  - If d!=0, go to SCAN. If d==0, stay in IDLE: the vector is consumed and produces no output beat, and count<=0.
- SCAN:
  - out_valid=1.
  - a = index of the lowest set bit of pend.
  - last = 1 iff pend has exactly one bit set.
  - count holds the captured popcount for every beat of the vector.
- SCAN, output handshake with last=0: clear bit a of pend; stay in SCAN.
- SCAN, output handshake with last=1 (vector done):
  - in_ready=1 in that same cycle.
  - If in_valid is also high, the new d is captured exactly as in IDLE, giving back-to-back vectors with no bubble.
  - Otherwise pend<=0, count<=0, and go to IDLE.
- SCAN in all other cycles: in_ready=0, and d is ignored.
- in_ready = (state==IDLE) | (state==SCAN & last & out_ready), gated low while rst=1. This is the only combinational input-to-output path.
- a, last, out_valid and count are functions of registers only.
- Backpressure: while out_valid=1 and out_ready=0, pend is unchanged, so a, last and count stay stable.
- Outside SCAN: a=0, last=0.

## Timing
- Reset:
  - While rst=1 at a clock edge: state<=IDLE, pend<=0, count<=0.
  - Outputs after reset: out_valid=0, a=0, last=0, count=0, in_ready=1. in_ready is 0 while rst is high.
- Reset mid-SCAN abandons the pending indices; none are emitted afterwards.
- Latency: a vector captured at edge N has its first beat valid in the cycle after edge N.
- Throughput:
  - A vector with k set bits takes exactly k output handshakes, at most one per cycle.
  - With out_ready held high, beats are emitted in k consecutive cycles.
  - A following vector presented with in_valid high gets its first beat in the next cycle.
- in_valid and d are sampled only on the input handshake edge; the producer may change d freely otherwise.
- rst has priority over all handshakes in the same cycle.

## Test plan
- **Reset:** capture d=8'h0F, complete 1 beat, then assert rst for 2 cycles -> outputs out_valid=0, a=0, last=0, count=0, in_ready=1; no further beats of 8'h0F appear.
- **Multi-hot ordering:** d=8'hA6 with out_ready=1 ->
  - beats a=1,2,5,7 on 4 consecutive cycles;
  - last=1 only on a=7;
  - count=4 on all beats;
  - in_ready=0 until the last handshake.
- **Backpressure:** d=8'h81, out_ready=0 for 3 cycles -> a=0, last=0, count=2 held stable; then out_ready=1 -> a=0, then a=7 with last=1.
- **Back-to-back:** d=8'h03, then d=8'h10 held with in_valid=1 and out_ready=1 -> beats a=0, a=1 (last), a=4 (last, count=1) in 3 consecutive cycles, with no idle cycle between vectors.
- **Zero vector:** d=8'h00 accepted -> no out_valid, state stays IDLE, in_ready stays 1. A following d=8'h40 yields a single beat a=6, last=1, count=1.
- **Full vector:** d=8'hFF -> 8 beats a=0..7, count=8, last only on a=7. Randomized out_ready gives the same sequence, with a held stable during stalls.

Source files
------------

// File: rtl/enc_8_3_seq.sv
// Sequential 8-to-3 encoder: accepts a multi-hot vector and streams the index
// of each set bit, lowest first, one index per output handshake.
module enc_8_3_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] d,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] a,
  output logic       last,
  output logic [3:0] count
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t     state, state_next;
  logic [7:0] pend, pend_next;
  logic [3:0] cnt, cnt_next;
  logic [2:0] low_idx;
  logic       one_left;
  logic       take_in;
  logic       beat;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] pc;
    pc = 4'd0;
    for (int i = 0; i < 8; i++) pc = pc + {3'b000, v[i]};
    return pc;
  endfunction

  // Descending scan so the lowest set bit is the last (winning) assignment.
  always_comb begin
    low_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (pend[i]) low_idx = i[2:0];
    end
  end

  assign one_left  = (pend != 8'd0) && ((pend & (pend - 8'd1)) == 8'd0);
  assign out_valid = (state == SCAN);
  assign a         = out_valid ? low_idx : 3'd0;
  assign last      = out_valid & one_left;
  assign count     = cnt;
  assign in_ready  = ~rst & ((state == IDLE) | (out_valid & one_left & out_ready));
  assign take_in   = in_valid & in_ready;
  assign beat      = out_valid & out_ready;

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    pend_next  = pend;
    cnt_next   = cnt;
    if (take_in) begin
      // A zero vector is consumed without producing any output beat.
      pend_next  = d;
      cnt_next   = popcount8(d);
      state_next = (d != 8'd0) ? SCAN : IDLE;
    end else if (beat) begin
      if (one_left) begin
        pend_next  = 8'd0;
        cnt_next   = 4'd0;
        state_next = IDLE;
      end else begin
        pend_next = pend & ~(8'd1 << low_idx);
      end
    end
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // values from before this edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pend  <= 8'd0;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      pend  <= pend_next;
      cnt   <= cnt_next;
    end
  end

endmodule

// File: tb/tb_enc_8_3_seq.sv
// Directed self-checking bench for enc_8_3_seq: reset, ordering, backpressure,
// back-to-back vectors, zero and full vectors.
module tb_enc_8_3_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] d;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] a;
  logic       last;
  logic [3:0] count;

  int n_checks = 0;
  int n_pass   = 0;

  enc_8_3_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d         (d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a         (a),
    .last      (last),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one edge; inputs are then driven at +1 and outputs sampled at +2.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic ov, input logic [2:0] ea,
                            input logic el, input logic [3:0] ec, input logic eir);
    #1;
    check({tag, ".out_valid"}, {7'd0, out_valid}, {7'd0, ov});
    check({tag, ".a"},         {5'd0, a},         {5'd0, ea});
    check({tag, ".last"},      {7'd0, last},      {7'd0, el});
    check({tag, ".count"},     {4'd0, count},     {4'd0, ec});
    check({tag, ".in_ready"},  {7'd0, in_ready},  {7'd0, eir});
  endtask

  task automatic load(input logic [7:0] v);
    in_valid = 1'b1;
    d        = v;
    tick();
    in_valid = 1'b0;
    d        = 8'h5A;
  endtask

  initial begin
    logic [7:0] a6_idx [4];
    int idx;
    int budget;

    a6_idx = '{8'd1, 8'd2, 8'd5, 8'd7};
    rst = 1'b1; in_valid = 1'b0; d = 8'h00; out_ready = 1'b0;
    tick(); tick();
    expect_out("rst_held", 1'b0, 3'd0, 1'b0, 4'd0, 1'b0);
    rst = 1'b0;
    expect_out("after_rst", 1'b0, 3'd0, 1'b0, 4'd0, 1'b1);

    // Reset mid-SCAN abandons the remaining indices of 8'h0F.
    out_ready = 1'b1;
    load(8'h0F);
    expect_out("r0f_b0", 1'b1, 3'd0, 1'b0, 4'd4, 1'b0);
    tick();
    rst = 1'b1;
    expect_out("r0f_rst", 1'b1, 3'd1, 1'b0, 4'd4, 1'b0);
    tick(); tick();
    rst = 1'b0;
    expect_out("r0f_post", 1'b0, 3'd0, 1'b0, 4'd0, 1'b1);
    tick();
    expect_out("r0f_post2", 1'b0, 3'd0, 1'b0, 4'd0, 1'b1);

    // Multi-hot ordering with the consumer always ready.
    load(8'hA6);
    for (int k = 0; k < 4; k++) begin
      expect_out($sformatf("a6_b%0d", k), 1'b1, a6_idx[k][2:0], k == 3, 4'd4, k == 3);
      tick();
    end
    expect_out("a6_done", 1'b0, 3'd0, 1'b0, 4'd0, 1'b1);

    // Backpressure holds the current beat stable.
    out_ready = 1'b0;
    load(8'h81);
    for (int k = 0; k < 3; k++) begin
      expect_out($sformatf("bp_stall%0d", k), 1'b1, 3'd0, 1'b0, 4'd2, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    expect_out("bp_b0", 1'b1, 3'd0, 1'b0, 4'd2, 1'b0);
    tick();
    expect_out("bp_b1", 1'b1, 3'd7, 1'b1, 4'd2, 1'b1);
    tick();
    expect_out("bp_done", 1'b0, 3'd0, 1'b0, 4'd0, 1'b1);

    // Back-to-back: second vector captured on the last beat of the first.
    in_valid = 1'b1; d = 8'h03;
    tick();
    d = 8'h10;
    expect_out("b2b_b0", 1'b1, 3'd0, 1'b0, 4'd2, 1'b0);
    tick();
    expect_out("b2b_b1", 1'b1, 3'd1, 1'b1, 4'd2, 1'b1);
    tick();
    in_valid = 1'b0;
    expect_out("b2b_b2", 1'b1, 3'd4, 1'b1, 4'd1, 1'b1);
    tick();
    expect_out("b2b_done", 1'b0, 3'd0, 1'b0, 4'd0, 1'b1);

    // Zero vector produces no beat; the next vector works normally.
    load(8'h00);
    expect_out("zero_0", 1'b0, 3'd0, 1'b0, 4'd0, 1'b1);
    tick();
    expect_out("zero_1", 1'b0, 3'd0, 1'b0, 4'd0, 1'b1);
    load(8'h40);
    expect_out("x40_b0", 1'b1, 3'd6, 1'b1, 4'd1, 1'b1);
    tick();
    expect_out("x40_done", 1'b0, 3'd0, 1'b0, 4'd0, 1'b1);

    // Full vector, consumer always ready.
    load(8'hFF);
    for (int k = 0; k < 8; k++) begin
      expect_out($sformatf("ff_b%0d", k), 1'b1, k[2:0], k == 7, 4'd8, k == 7);
      tick();
    end
    expect_out("ff_done", 1'b0, 3'd0, 1'b0, 4'd0, 1'b1);

    // Full vector, random stalls: same sequence, a held during stalls.
    out_ready = 1'b0;
    load(8'hFF);
    idx = 0;
    budget = 0;
    while (idx < 8 && budget < 200) begin
      out_ready = 1'($urandom_range(0, 1));
      expect_out($sformatf("ffr_%0d", idx), 1'b1, idx[2:0], idx == 7, 4'd8,
                 (idx == 7) && out_ready);
      tick();
      if (out_ready) idx++;
      budget++;
    end
    check("ffr_budget", idx[7:0], 8'd8);
    out_ready = 1'b1;
    expect_out("ffr_done", 1'b0, 3'd0, 1'b0, 4'd0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
